// File: rtl/rx_host_sched_if.sv
// Requester, config and rx_host register-port signals of the host command scheduler.
// The scheduler sits on the slave modport; requesters, config master and host model use master.
interface rx_host_sched_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]    req;
  logic [NREQ*21-1:0] req_data;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    resp_valid;
  logic [15:0]        resp_data;
  logic               resp_err;
  logic               cfg_valid;
  logic [1:0]         cfg_addr;
  logic [31:0]        cfg_data;
  logic               cfg_ready;
  logic               host_wvalid;
  logic [1:0]         host_addr;
  logic [31:0]        host_wdata;
  logic               host_rvalid;
  logic [15:0]        host_rdata;
  logic               busy;

  modport master (
    output req, req_data, cfg_valid, cfg_addr, cfg_data, host_rvalid, host_rdata,
    input  gnt, resp_valid, resp_data, resp_err, cfg_ready, host_wvalid, host_addr,
           host_wdata, busy
  );

  modport slave (
    input  req, req_data, cfg_valid, cfg_addr, cfg_data, host_rvalid, host_rdata,
    output gnt, resp_valid, resp_data, resp_err, cfg_ready, host_wvalid, host_addr,
           host_wdata, busy
  );
endinterface

// File: rtl/rx_host_sched.sv
// Round-robin command scheduler for the single per-frame command slot of the rx_host link,
// with outstanding-read tracking (data or frame timeout) and a config-write side port.
module rx_host_sched #(
  parameter int NREQ           = 4,
  parameter int ISSUE_CYCLE    = 8,
  parameter int TIMEOUT_FRAMES = 4
) (
  input  logic           clock,
  input  logic           reset_n,
  input  logic           frame_start,
  rx_host_sched_if.slave bus
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {ST_IDLE, ST_WAIT_RD} state_t;

  state_t          r_state, w_state_nxt;
  logic [8:0]      r_fcnt;
  logic            r_synced;
  logic [PW-1:0]   r_ptr, w_ptr_nxt;
  logic [PW-1:0]   r_owner, w_owner_nxt;
  logic [PW-1:0]   w_win, w_idx;
  logic [3:0]      r_tmo, w_tmo_nxt;
  logic            w_found, w_slot, w_cfg_acc;
  logic [20:0]     w_cmd;
  logic [NREQ-1:0] r_gnt, w_gnt_nxt;
  logic [NREQ-1:0] r_resp_valid, w_resp_valid_nxt;
  logic [15:0]     r_resp_data, w_resp_data_nxt;
  logic            r_resp_err, w_resp_err_nxt;
  logic            r_wvalid, w_wvalid_nxt;
  logic [1:0]      r_addr, w_addr_nxt;
  logic [31:0]     r_wdata, w_wdata_nxt;
  logic            r_busy;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_fcnt   <= '0;
      r_synced <= 1'b0;
    end else if (frame_start) begin
      r_fcnt   <= '0;
      r_synced <= 1'b1;
    end else if (r_fcnt != 9'd511) begin
      r_fcnt <= r_fcnt + 9'd1;
    end
  end

  // First pending requester at or after the round-robin pointer, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = PW'((int'(r_ptr) + k) % NREQ);
      if (!w_found && bus.req[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  always_comb begin
    w_cmd = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_win == PW'(i)) w_cmd = bus.req_data[21*i +: 21];
    end
  end

  assign w_slot        = r_synced && (r_fcnt == 9'(ISSUE_CYCLE)) && (r_state == ST_IDLE) && w_found;
  assign bus.cfg_ready = !w_slot;
  assign w_cfg_acc     = bus.cfg_valid && !w_slot;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt      = r_state;
    w_ptr_nxt        = r_ptr;
    w_owner_nxt      = r_owner;
    w_tmo_nxt        = r_tmo;
    w_gnt_nxt        = '0;
    w_wvalid_nxt     = 1'b0;
    w_addr_nxt       = '0;
    w_wdata_nxt      = '0;
    w_resp_valid_nxt = '0;
    w_resp_data_nxt  = '0;
    w_resp_err_nxt   = 1'b0;

    if (w_slot) begin
      w_gnt_nxt[w_win] = 1'b1;
      w_wvalid_nxt     = 1'b1;
      w_addr_nxt       = 2'd0;
      w_wdata_nxt      = {11'b0, w_cmd};
      w_ptr_nxt        = (w_win == PW'(NREQ - 1)) ? '0 : w_win + 1'b1;
      if (w_cmd[20]) begin
        w_state_nxt = ST_WAIT_RD;
        w_owner_nxt = w_win;
        w_tmo_nxt   = '0;
      end
    end else if (w_cfg_acc && (bus.cfg_addr != 2'd0)) begin
      w_wvalid_nxt = 1'b1;
      w_addr_nxt   = bus.cfg_addr;
      w_wdata_nxt  = bus.cfg_data;
    end

    // Read data beats a timeout landing in the same cycle.
    if (r_state == ST_WAIT_RD) begin
      if (bus.host_rvalid) begin
        w_resp_valid_nxt[r_owner] = 1'b1;
        w_resp_data_nxt           = bus.host_rdata;
        w_state_nxt               = ST_IDLE;
      end else if (frame_start) begin
        if (r_tmo == 4'(TIMEOUT_FRAMES - 1)) begin
          w_resp_valid_nxt[r_owner] = 1'b1;
          w_resp_err_nxt            = 1'b1;
          w_state_nxt               = ST_IDLE;
        end else begin
          w_tmo_nxt = r_tmo + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_ptr        <= '0;
      r_owner      <= '0;
      r_tmo        <= '0;
      r_gnt        <= '0;
      r_wvalid     <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_resp_valid <= '0;
      r_resp_data  <= '0;
      r_resp_err   <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_ptr        <= w_ptr_nxt;
      r_owner      <= w_owner_nxt;
      r_tmo        <= w_tmo_nxt;
      r_gnt        <= w_gnt_nxt;
      r_wvalid     <= w_wvalid_nxt;
      r_addr       <= w_addr_nxt;
      r_wdata      <= w_wdata_nxt;
      r_resp_valid <= w_resp_valid_nxt;
      r_resp_data  <= w_resp_data_nxt;
      r_resp_err   <= w_resp_err_nxt;
      r_busy       <= (w_state_nxt == ST_WAIT_RD);
    end
  end

  assign bus.gnt         = r_gnt;
  assign bus.host_wvalid = r_wvalid;
  assign bus.host_addr   = r_addr;
  assign bus.host_wdata  = r_wdata;
  assign bus.resp_valid  = r_resp_valid;
  assign bus.resp_data   = r_resp_data;
  assign bus.resp_err    = r_resp_err;
  assign bus.busy        = r_busy;
endmodule

// File: tb/tb_rx_host_sched.sv
// Scoreboard bench for rx_host_sched: directed stimulus pushes expected grants, host writes and
// read completions; a negedge monitor pops and compares whenever the DUT presents one.
module tb_rx_host_sched;
  localparam int NREQ  = 4;
  localparam int ISSUE = 8;

  typedef struct {
    logic [1:0]  addr;
    logic [31:0] data;
    int          age;
  } wr_t;

  typedef struct {
    logic [3:0]  vld;
    logic [15:0] data;
    logic        err;
    int          age;
  } resp_t;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic frame_start = 1'b0;

  rx_host_sched_if #(.NREQ(NREQ)) bus ();

  rx_host_sched #(.NREQ(NREQ), .ISSUE_CYCLE(ISSUE), .TIMEOUT_FRAMES(4)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .frame_start(frame_start),
    .bus        (bus)
  );

  always #4 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  int age      = 0;

  logic [3:0] q_gnt[$];
  wr_t        q_wr[$];
  resp_t      q_resp[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Age counts cycles since the frame_start cycle (age 0); fcnt in the DUT equals age - 1.
  always @(negedge clock) begin
    if (frame_start) age = 0;
    else age = age + 1;

    if (bus.gnt != '0) begin
      if (q_gnt.size() == 0) check("gnt_unexpected", bus.gnt, 0);
      else begin
        logic [3:0] eg;
        eg = q_gnt.pop_front();
        check("gnt_vector", bus.gnt, eg);
        check("gnt_cycle", age, ISSUE + 2);
      end
    end

    if (bus.host_wvalid) begin
      if (q_wr.size() == 0) check("wr_unexpected", {bus.host_addr, bus.host_wdata[29:0]}, 0);
      else begin
        wr_t ew;
        ew = q_wr.pop_front();
        check("wr_addr", bus.host_addr, ew.addr);
        check("wr_data", bus.host_wdata, ew.data);
        if (ew.age >= 0) check("wr_cycle", age, ew.age);
      end
    end

    if (bus.resp_valid != '0) begin
      if (q_resp.size() == 0) check("resp_unexpected", bus.resp_valid, 0);
      else begin
        resp_t er;
        er = q_resp.pop_front();
        check("resp_valid", bus.resp_valid, er.vld);
        check("resp_data", bus.resp_data, er.data);
        check("resp_err", bus.resp_err, er.err);
        if (er.age >= 0) check("resp_cycle", age, er.age);
      end
    end
  end

  task automatic step(input logic fs = 1'b0, input logic rv = 1'b0, input logic [15:0] rd = 16'h0);
    frame_start     = fs;
    bus.host_rvalid = rv;
    bus.host_rdata  = rd;
    @(posedge clock);
    #1;
    frame_start     = 1'b0;
    bus.host_rvalid = 1'b0;
    bus.req         = bus.req & ~bus.gnt;
  endtask

  task automatic frames(input int n);
    for (int f = 0; f < n; f++) begin
      step(1'b1);
      repeat (511) step();
    end
  endtask

  task automatic do_reset();
    reset_n         = 1'b0;
    bus.req         = '0;
    bus.cfg_valid   = 1'b0;
    bus.host_rvalid = 1'b0;
    frame_start     = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    bus.req         = '0;
    bus.req_data    = '0;
    bus.cfg_valid   = 1'b0;
    bus.cfg_addr    = '0;
    bus.cfg_data    = '0;
    bus.host_rvalid = 1'b0;
    bus.host_rdata  = '0;
    #1;
    check("rst_gnt", bus.gnt, 0);
    check("rst_wvalid", bus.host_wvalid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_resp_valid", bus.resp_valid, 0);
    check("rst_cfg_ready", bus.cfg_ready, 1);
    do_reset();

    // 1: no issue before the first frame_start, then slot at fcnt ISSUE_CYCLE
    bus.req_data[20:0] = 21'h0_3_1234;
    bus.req = 4'b0001;
    repeat (30) step();
    check("t1_unsynced_req_held", bus.req, 4'b0001);
    q_gnt.push_back(4'b0001);
    q_wr.push_back('{2'd0, 32'h0003_1234, ISSUE + 2});
    frames(1);
    check("t1_req_dropped", bus.req, 0);

    // 2: round robin from a fresh pointer, one grant per frame
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      bus.req_data[21*i +: 21] = {1'b0, 4'(i + 4), 16'hC0D0 + 16'(i)};
      q_gnt.push_back(4'(1 << i));
      q_wr.push_back('{2'd0, {11'b0, 1'b0, 4'(i + 4), 16'hC0D0 + 16'(i)}, ISSUE + 2});
    end
    bus.req = 4'b1111;
    frames(4);
    check("t2_all_granted", bus.req, 0);
    bus.req_data[20:0]  = 21'h0_A_0A0A;
    bus.req_data[83:63] = 21'h0_B_0B0B;
    bus.req = 4'b1001;
    q_gnt.push_back(4'b0001);
    q_wr.push_back('{2'd0, 32'h000A_0A0A, ISSUE + 2});
    q_gnt.push_back(4'b1000);
    q_wr.push_back('{2'd0, 32'h000B_0B0B, ISSUE + 2});
    frames(2);
    step(1'b0, 1'b1, 16'h1234);

    // 3: read from req 2 answered mid-frame; req 0 waits for the next frame
    bus.req_data[62:42] = 21'h1_5_0000;
    bus.req = 4'b0100;
    q_gnt.push_back(4'b0100);
    q_wr.push_back('{2'd0, 32'h0015_0000, ISSUE + 2});
    q_resp.push_back('{4'b0100, 16'hBEEF, 1'b0, -1});
    step(1'b1);
    repeat (20) step();
    check("t3_busy_set", bus.busy, 1);
    bus.req_data[20:0] = 21'h0_7_AAAA;
    bus.req[0] = 1'b1;
    repeat (280) step();
    step(1'b0, 1'b1, 16'hBEEF);
    repeat (5) step();
    check("t3_busy_clear", bus.busy, 0);
    check("t3_req0_waiting", bus.req, 4'b0001);
    repeat (205) step();
    q_gnt.push_back(4'b0001);
    q_wr.push_back('{2'd0, 32'h0007_AAAA, ISSUE + 2});
    frames(1);

    // 4: read from req 1 with no answer times out right after the 4th later frame_start
    bus.req_data[41:21] = 21'h1_2_0000;
    bus.req = 4'b0010;
    q_gnt.push_back(4'b0010);
    q_wr.push_back('{2'd0, 32'h0012_0000, ISSUE + 2});
    q_resp.push_back('{4'b0010, 16'h0000, 1'b1, 1});
    frames(1);
    check("t4_busy_waiting", bus.busy, 1);
    frames(4);
    check("t4_busy_done", bus.busy, 0);

    // 5: config write held through the slot cycle follows the command write
    bus.req_data[83:63] = 21'h0_9_0055;
    bus.req = 4'b1000;
    q_gnt.push_back(4'b1000);
    q_wr.push_back('{2'd0, 32'h0009_0055, ISSUE + 2});
    q_wr.push_back('{2'd1, 32'h0000_0003, ISSUE + 3});
    step(1'b1);
    repeat (7) step();
    check("t5_ready_before_slot", bus.cfg_ready, 1);
    step();
    bus.cfg_valid = 1'b1;
    bus.cfg_addr  = 2'd1;
    bus.cfg_data  = 32'd3;
    check("t5_ready_slot", bus.cfg_ready, 0);
    step();
    check("t5_ready_after_slot", bus.cfg_ready, 1);
    step();
    bus.cfg_valid = 1'b0;
    repeat (30) step();
    bus.cfg_valid = 1'b1;
    bus.cfg_addr  = 2'd0;
    bus.cfg_data  = 32'hFFFF_FFFF;
    step();
    bus.cfg_addr  = 2'd2;
    bus.cfg_data  = 32'hA5A5_0001;
    q_wr.push_back('{2'd2, 32'hA5A5_0001, -1});
    step();
    bus.cfg_valid = 1'b0;
    repeat (469) step();

    // 6: reset during an outstanding read abandons it; issue resumes after a frame_start
    bus.req_data[20:0] = 21'h1_1_0000;
    bus.req = 4'b0001;
    q_gnt.push_back(4'b0001);
    q_wr.push_back('{2'd0, 32'h0011_0000, ISSUE + 2});
    step(1'b1);
    repeat (20) step();
    check("t6_busy_before_rst", bus.busy, 1);
    #2 reset_n = 1'b0;
    #1;
    check("t6_rst_busy", bus.busy, 0);
    check("t6_rst_wvalid", bus.host_wvalid, 0);
    check("t6_rst_cfg_ready", bus.cfg_ready, 1);
    bus.req = '0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    step(1'b0, 1'b1, 16'hDEAD);
    bus.req_data[41:21] = 21'h0_4_0004;
    bus.req = 4'b0010;
    repeat (30) step();
    check("t6_no_issue_unsynced", bus.req, 4'b0010);
    q_gnt.push_back(4'b0010);
    q_wr.push_back('{2'd0, 32'h0004_0004, ISSUE + 2});
    frames(1);
    check("t6_resumed", bus.req, 0);

    check("q_gnt_drained", q_gnt.size(), 0);
    check("q_wr_drained", q_wr.size(), 0);
    check("q_resp_drained", q_resp.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
